// File: rtl/freq_monitor.sv
// freq_monitor
// Clock-health monitor for the freq_gauge output. A free-running counter
// produces one sample tick every SamplePeriod clocks. Each tick checks the
// measured frequency against a fixed window [lo, hi]. Hysteresis counters
// qualify lock and loss-of-lock. Status, the last sample, min/max history
// and a loss counter are exposed over a small Avalon-MM slave.
//
// Ports
//   clk           in   1  only clock
//   reset         in   1  synchronous, active-high; clears all state
//   freq_hz       in  32  measured frequency in Hz (freq_gauge readdata)
//   mm_address    in   3  register word address
//   mm_read       in   1  read strobe, data returned one cycle later
//   mm_write      in   1  write strobe, takes effect at the same edge
//   mm_writedata  in  32  write data
//   mm_readdata   out 32  read data, held until the next read
//   locked        out  1  high while in the LOCKED state
//   alarm         out  1  sticky loss-of-lock flag
//
// Register map (word addresses)
//   0 status  R: [1:0] state, [2] alarm   W: bit0 clear alarm, bit1 clear stats
//   1 last sample   2 min   3 max   4 loss count   5..7 read as zero
module freq_monitor #(
    parameter logic [31:0] ExpectedFreq = 32'd106250000,
    parameter logic [31:0] Tolerance    = 32'd21250,
    parameter int unsigned SamplePeriod = 1000000,
    parameter int unsigned LockCount    = 4,
    parameter int unsigned UnlockCount  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] freq_hz,
    input  logic [2:0]  mm_address,
    input  logic        mm_read,
    input  logic        mm_write,
    input  logic [31:0] mm_writedata,
    output logic [31:0] mm_readdata,
    output logic        locked,
    output logic        alarm
);

    localparam int unsigned   CntW     = (SamplePeriod > 1) ? $clog2(SamplePeriod) : 1;
    localparam logic [CntW-1:0] TickLast = CntW'(SamplePeriod - 1);

    // Window bounds, fixed at elaboration: lo clamps at 0, hi saturates.
    localparam logic [32:0] HiSum = {1'b0, ExpectedFreq} + {1'b0, Tolerance};
    localparam logic [31:0] WinHi = HiSum[32] ? 32'hFFFF_FFFF : HiSum[31:0];
    localparam logic [31:0] WinLo = (Tolerance > ExpectedFreq) ? 32'd0
                                                               : (ExpectedFreq - Tolerance);

    typedef enum logic [1:0] {
        S_ACQUIRE = 2'd0,
        S_LOCKED  = 2'd1,
        S_LOST    = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic [CntW-1:0] r_tick_cnt;
    state_t          r_state;
    logic [31:0]     r_run;
    logic [31:0]     r_last;
    logic [31:0]     r_min;
    logic [31:0]     r_max;
    logic [31:0]     r_loss_cnt;
    logic            r_alarm;
    logic [31:0]     r_rdata;

    state_t          w_state_nxt;
    logic [31:0]     w_run_nxt;
    logic            w_loss_evt;
    logic            w_tick;
    logic            w_in_range;
    logic            w_wr_ctl;
    logic            w_clr_alarm;
    logic            w_clr_stats;
    logic [31:0]     w_rd_mux;
    logic            w_unused_wdata;

    assign w_tick      = (r_tick_cnt == TickLast);
    // A zero sample means the gauge has no clock to measure, even if lo is 0.
    assign w_in_range  = (freq_hz != 32'd0) && (freq_hz >= WinLo) && (freq_hz <= WinHi);
    assign w_wr_ctl    = mm_write && (mm_address == 3'd0);
    assign w_clr_alarm = w_wr_ctl && mm_writedata[0];
    assign w_clr_stats = w_wr_ctl && mm_writedata[1];

    assign w_unused_wdata = &{1'b0, mm_writedata[31:2]};

    assign locked      = (r_state == S_LOCKED);
    assign alarm       = r_alarm;
    assign mm_readdata = r_rdata;

    // ---- sample tick ----
    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CntW'(1);
        end
    end

    // ---- lock FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_ACQUIRE;
            r_run   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // ---- lock FSM: next state ----
    // run counts consecutive samples that argue for leaving the current
    // state; it restarts from 0 on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_loss_evt  = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_ACQUIRE, S_LOST: begin
                    if (w_in_range) begin
                        if (r_run + 32'd1 == LockCount) begin
                            w_state_nxt = S_LOCKED;
                            w_run_nxt   = 32'd0;
                        end else begin
                            w_run_nxt = r_run + 32'd1;
                        end
                    end else begin
                        w_run_nxt = 32'd0;
                    end
                end
                S_LOCKED: begin
                    if (!w_in_range) begin
                        if (r_run + 32'd1 == UnlockCount) begin
                            w_state_nxt = S_LOST;
                            w_run_nxt   = 32'd0;
                            w_loss_evt  = 1'b1;
                        end else begin
                            w_run_nxt = r_run + 32'd1;
                        end
                    end else begin
                        w_run_nxt = 32'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_ACQUIRE;
                    w_run_nxt   = 32'd0;
                end
            endcase
        end
    end

    // ---- history, alarm and loss counter ----
    // Same-edge conflicts: a loss event beats an alarm clear, and a stats
    // clear on a tick edge seeds min/max with the new sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last     <= 32'd0;
            r_min      <= 32'hFFFF_FFFF;
            r_max      <= 32'd0;
            r_loss_cnt <= 32'd0;
            r_alarm    <= 1'b0;
        end else begin
            if (w_tick) begin
                r_last <= freq_hz;
            end

            if (w_tick && w_clr_stats) begin
                r_min <= freq_hz;
                r_max <= freq_hz;
            end else if (w_clr_stats) begin
                r_min <= 32'hFFFF_FFFF;
                r_max <= 32'd0;
            end else if (w_tick) begin
                if (freq_hz < r_min) r_min <= freq_hz;
                if (freq_hz > r_max) r_max <= freq_hz;
            end

            if (w_loss_evt) begin
                r_loss_cnt <= w_clr_stats ? 32'd1 : sat_inc32(r_loss_cnt);
            end else if (w_clr_stats) begin
                r_loss_cnt <= 32'd0;
            end

            if (w_loss_evt) begin
                r_alarm <= 1'b1;
            end else if (w_clr_alarm) begin
                r_alarm <= 1'b0;
            end
        end
    end

    // ---- register read ----
    always_comb begin
        w_rd_mux = 32'd0;
        case (mm_address)
            3'd0:    w_rd_mux = {29'd0, r_alarm, r_state};
            3'd1:    w_rd_mux = r_last;
            3'd2:    w_rd_mux = r_min;
            3'd3:    w_rd_mux = r_max;
            3'd4:    w_rd_mux = r_loss_cnt;
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Captures pre-edge values, so a read paired with a write sees old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (mm_read) begin
            r_rdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_freq_monitor.sv
// Directed testbench for freq_monitor with SamplePeriod=4, LockCount=3,
// UnlockCount=2. A second instance with Tolerance=0xFFFFFFFF covers the
// clamped-lo window case.
module tb_freq_monitor;

    localparam logic [31:0] F0   = 32'd106250000;
    localparam logic [31:0] FHI  = 32'd106271250;
    localparam logic [31:0] FLO  = 32'd106228750;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] freq_hz = 32'd0;
    logic [2:0]  mm_address = 3'd0;
    logic        mm_read = 1'b0;
    logic        mm_write = 1'b0;
    logic [31:0] mm_writedata = 32'd0;
    logic [31:0] mm_readdata;
    logic        locked;
    logic        alarm;
    logic [31:0] wide_readdata;
    logic        wide_locked;
    logic        wide_alarm;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;   // edges since the last expected tick, mod 4

    always #5 clk = ~clk;

    freq_monitor #(
        .SamplePeriod(4), .LockCount(3), .UnlockCount(2)
    ) dut (
        .clk(clk), .reset(reset), .freq_hz(freq_hz),
        .mm_address(mm_address), .mm_read(mm_read), .mm_write(mm_write),
        .mm_writedata(mm_writedata), .mm_readdata(mm_readdata),
        .locked(locked), .alarm(alarm)
    );

    freq_monitor #(
        .Tolerance(32'hFFFF_FFFF), .SamplePeriod(4), .LockCount(3), .UnlockCount(2)
    ) dut_wide (
        .clk(clk), .reset(reset), .freq_hz(freq_hz),
        .mm_address(mm_address), .mm_read(mm_read), .mm_write(mm_write),
        .mm_writedata(mm_writedata), .mm_readdata(wide_readdata),
        .locked(wide_locked), .alarm(wide_alarm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 4;
        end
    endtask

    task automatic do_reset();
        mm_read  = 1'b0;
        mm_write = 1'b0;
        reset    = 1'b1;
        step(1);
        reset    = 1'b0;
        phase    = 0;
    endtask

    // One bus cycle; rdata is the value presented after the edge.
    task automatic bus(input logic [2:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, output logic [31:0] rdata);
        mm_address   = a;
        mm_read      = rd;
        mm_write     = wr;
        mm_writedata = wd;
        step(1);
        mm_read  = 1'b0;
        mm_write = 1'b0;
        rdata    = mm_readdata;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus(a, 1'b1, 1'b0, 32'd0, d);
        chk(tag, d, exp);
    endtask

    // Present v and advance to the next tick edge; optionally write the
    // status register on that same tick edge.
    task automatic sample(input logic [31:0] v, input logic wr, input logic [31:0] wd);
        freq_hz = v;
        if (phase < 3) step(3 - phase);
        mm_address   = 3'd0;
        mm_write     = wr;
        mm_writedata = wd;
        step(1);
        mm_write = 1'b0;
    endtask

    // Twelve edges after reset: lock appears exactly at edge 12. Reads in
    // the first four edges observe reset values of min/max/loss/last.
    task automatic lock_window(input string pfx);
        logic [2:0]  addr_t [4] = '{3'd2, 3'd3, 3'd4, 3'd1};
        logic [31:0] exp_t  [4] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        for (int e = 1; e <= 12; e++) begin
            if (e <= 4) begin
                mm_address = addr_t[e-1];
                mm_read    = 1'b1;
            end
            step(1);
            mm_read = 1'b0;
            chk($sformatf("%s_locked_e%0d", pfx, e), {31'd0, locked}, {31'd0, (e >= 12)});
            if (e <= 4) chk($sformatf("%s_rst_reg_e%0d", pfx, e), mm_readdata, exp_t[e-1]);
        end
    endtask

    initial begin
        logic [31:0] d;

        // Lock from reset
        freq_hz = F0;
        do_reset();
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_alarm", {31'd0, alarm}, 32'd0);
        chk("rst_rdata", mm_readdata, 32'd0);
        lock_window("t1");
        rd_chk("t1_status", 3'd0, 32'h1);
        rd_chk("t1_last", 3'd1, F0);
        rd_chk("t1_min", 3'd2, F0);

        // Loss and hysteresis
        sample(32'd0, 1'b0, 32'd0);
        chk("t3_one_bad", {31'd0, locked}, 32'd1);
        sample(F0, 1'b0, 32'd0);
        chk("t3_recover", {31'd0, locked}, 32'd1);
        sample(32'd0, 1'b0, 32'd0);
        chk("t3_bad1", {31'd0, locked}, 32'd1);
        sample(32'd0, 1'b0, 32'd0);
        chk("t3_lost_locked", {31'd0, locked}, 32'd0);
        chk("t3_lost_alarm", {31'd0, alarm}, 32'd1);
        rd_chk("t3_status", 3'd0, 32'h6);
        rd_chk("t3_loss", 3'd4, 32'd1);
        rd_chk("t3_max", 3'd3, F0);
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t3_relock2", {31'd0, locked}, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t3_relock3", {31'd0, locked}, 32'd1);
        chk("t3_alarm_sticky", {31'd0, alarm}, 32'd1);

        // Alarm clear, with a simultaneous read returning the old status
        bus(3'd0, 1'b1, 1'b1, 32'h1, d);
        chk("t4_rw_status", d, 32'h5);
        chk("t4_alarm_clr", {31'd0, alarm}, 32'd0);
        sample(32'd0, 1'b0, 32'd0);
        sample(32'd0, 1'b1, 32'h1);
        chk("t4_set_wins", {31'd0, alarm}, 32'd1);
        chk("t4_locked", {31'd0, locked}, 32'd0);
        rd_chk("t4_loss", 3'd4, 32'd2);
        rd_chk("t4_status", 3'd0, 32'h6);
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t4_relock", {31'd0, locked}, 32'd1);

        // Min/max history and stats clear
        bus(3'd0, 1'b0, 1'b1, 32'h2, d);
        rd_chk("t5_min_clr", 3'd2, 32'hFFFF_FFFF);
        rd_chk("t5_max_clr", 3'd3, 32'd0);
        rd_chk("t5_loss_clr", 3'd4, 32'd0);
        sample(32'd106250000, 1'b0, 32'd0);
        sample(32'd106260000, 1'b0, 32'd0);
        sample(32'd106240000, 1'b0, 32'd0);
        rd_chk("t5_min", 3'd2, 32'd106240000);
        rd_chk("t5_max", 3'd3, 32'd106260000);
        sample(32'd106255000, 1'b1, 32'h2);
        rd_chk("t5_min_seed", 3'd2, 32'd106255000);
        rd_chk("t5_max_seed", 3'd3, 32'd106255000);
        rd_chk("t5_loss_zero", 3'd4, 32'd0);

        // Reset mid-operation
        chk("t6_pre_locked", {31'd0, locked}, 32'd1);
        chk("t6_pre_alarm", {31'd0, alarm}, 32'd1);
        freq_hz = F0;
        do_reset();
        chk("t6_locked", {31'd0, locked}, 32'd0);
        chk("t6_alarm", {31'd0, alarm}, 32'd0);
        chk("t6_rdata", mm_readdata, 32'd0);
        lock_window("t6");

        // Window boundaries
        do_reset();
        sample(FHI, 1'b0, 32'd0);
        sample(FLO, 1'b0, 32'd0);
        chk("t2_edge2", {31'd0, locked}, 32'd0);
        sample(FHI, 1'b0, 32'd0);
        chk("t2_edge_lock", {31'd0, locked}, 32'd1);

        do_reset();
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        sample(32'd106271251, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t2_above_hi", {31'd0, locked}, 32'd0);
        sample(32'd106228749, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t2_below_lo", {31'd0, locked}, 32'd0);
        sample(32'd0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t2_zero", {31'd0, locked}, 32'd0);
        sample(F0, 1'b0, 32'd0);
        chk("t2_final_lock", {31'd0, locked}, 32'd1);

        do_reset();
        for (int i = 0; i < 4; i++) sample(32'd0, 1'b0, 32'd0);
        chk("t2_wide_zero", {31'd0, wide_locked}, 32'd0);
        for (int i = 0; i < 3; i++) sample(32'd1, 1'b0, 32'd0);
        chk("t2_wide_one", {31'd0, wide_locked}, 32'd1);
        chk("t2_narrow_one", {31'd0, locked}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_monitor.md
# freq_monitor

Clock-health monitor that sits directly downstream of `freq_gauge`. It periodically samples the measured frequency word and checks it against an expected value with a tolerance window. Hysteresis counters qualify lock and loss-of-lock. It exposes lock state, a sticky alarm, min/max history and a loss counter over a small Avalon-MM slave. The block runs on the same clock as the `freq_gauge` output it reads, so no CDC is needed.

## Interface
- `ExpectedFreq`, default 106250000: nominal frequency in Hz.
- `Tolerance`, default 21250: allowed deviation in Hz, inclusive on both sides.
- `SamplePeriod`, default 1000000: clocks between samples; must be ≥ 2.
- `LockCount`, default 4: consecutive in-range samples required to declare lock; must be ≥ 1.
- `UnlockCount`, default 2: consecutive out-of-range samples required to drop lock; must be ≥ 1.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `freq_hz` in 32: measured frequency, from `freq_gauge` `mm_readdata`.
- `mm_address` in 3: register word address.
- `mm_read` in 1: read strobe.
- `mm_write` in 1: write strobe.
- `mm_writedata` in 32: write data.
- `mm_readdata` out 32: read data.
- `locked` out 1: high while in the LOCKED state.
- `alarm` out 1: sticky loss-of-lock flag.

## Operation
- Sample tick: a free-running counter counts 0..SamplePeriod-1 and wraps. The tick is the edge at which the counter equals SamplePeriod-1. At each tick, `freq_hz` is captured into `last`.
- Window bounds:
  - lo = ExpectedFreq − Tolerance, clamped at 0.
  - hi = ExpectedFreq + Tolerance, saturated at 0xFFFFFFFF.
  - Computed at elaboration.
- In-range test: lo ≤ sample ≤ hi. A sample of 0 is always out of range.
- FSM, with states ACQUIRE=0, LOCKED=1, LOST=2. The run counter `run` resets to 0 on every state change.
  - ACQUIRE / LOST: an in-range sample increments `run`; an out-of-range sample clears it. When `run` reaches LockCount, go to LOCKED.
  - LOCKED: an out-of-range sample increments `run`; an in-range sample clears it. When `run` reaches UnlockCount, go to LOST. On that transition, set `alarm` and increment `loss_cnt`, saturating at 0xFFFFFFFF.
  - An acquisition failure in ACQUIRE never sets `alarm`.
- Min/max: updated on every tick. The reset values are min=0xFFFFFFFF and max=0.
- Register map, word addresses:
  - 0 status (RW):
    - Read: [1:0] state, [2] alarm, remaining bits 0.
    - Write bit0=1: clears `alarm`.
    - Write bit1=1: resets min, max and `loss_cnt`.
  - 1 `last` (RO).
  - 2 min (RO).
  - 3 max (RO).
  - 4 `loss_cnt` (RO).
  - 5–7 read as 0. Writes to addresses 1–7 are ignored.
- Simultaneous events:
  - Alarm clear in the same cycle as a new loss event: the set wins, so `alarm` = 1.
  - Min/max reset in the same cycle as a tick: min and max both load the new sample.
  - `loss_cnt` clear in the same cycle as a loss event: `loss_cnt` = 1.
- Reset:
  - All state returns to reset values on the edge where `reset` = 1, including the tick counter. This applies mid-operation as well.
  - Reset values: state ACQUIRE, `run` 0, `last` 0, min 0xFFFFFFFF, max 0, `loss_cnt` 0, `alarm` 0, `locked` 0, `mm_readdata` 0.

## Timing
- `locked`, `alarm` and state are registered. They reflect the sample from the tick at edge k starting after edge k, with no additional latency.
- First tick: the SamplePeriod-th edge after `reset` deasserts.
- Read latency is 1 cycle. `mm_readdata` is valid the cycle after `mm_read`, holds until the next read, and returns the register value as of the `mm_read` edge.
- Writes take effect at the `mm_write` edge. No wait-request.
- `mm_read` and `mm_write` asserted together: both are performed, and the read returns the pre-write value.

## Test plan
Unless noted, all scenarios use SamplePeriod=4, LockCount=3, UnlockCount=2, ExpectedFreq=106250000, Tolerance=21250.

1. Lock: hold `freq_hz`=106250000 from reset. Ticks occur at edges 4, 8 and 12. `locked` = 0 through edge 11 and 1 after edge 12. Status reads 0x1.
2. Window boundaries: samples of 106271250 and 106228750 count toward lock. A sample of 106271251, 106228749 or 0 clears `run` and lock is never reached. With Tolerance=0xFFFFFFFF, lo clamps to 0, but a sample of 0 is still rejected.
3. Loss and hysteresis: from LOCKED, apply one sample of 0 then in-range samples; the state stays LOCKED. Then apply two samples of 0: the state becomes LOST (status 0x6), `locked`=0, `alarm`=1 and `loss_cnt` reads 1. Three in-range samples then return the state to LOCKED while `alarm` stays 1.
4. Alarm clear: write 0x1 to address 0 and `alarm` goes to 0. Repeat with the write on the same edge as the second loss sample; `alarm` stays 1 and `loss_cnt` increments.
5. Min/max: apply samples 106250000, 106260000, 106240000. Min reads 106240000 and max reads 106260000. Write 0x2, then one tick of 106255000; min and max both read 106255000 and `loss_cnt` reads 0.
6. Reset mid-operation: assert `reset` for one cycle while LOCKED with `alarm`=1. The next cycle shows all reset values, and relock occurs exactly 12 edges after deassertion.
